// File: rtl/ibex_instr_sram_bridge.sv
// rtl/ibex_instr_sram_bridge.sv - instruction fetch slave to shared SRAM with range check and capped outstanding count
// Optional per-byte read parity checking is enabled by defining IBEX_IBUS_PARITY_EN.
module ibex_instr_sram_bridge #(
    parameter int unsigned AddrWidth      = 12,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_req_i,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,
    output logic                 sram_req_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    input  logic                 sram_gnt_i,
    input  logic [31:0]          sram_rdata_i,
`ifdef IBEX_IBUS_PARITY_EN
    input  logic [3:0]           sram_parity_i,
`endif
    output logic                 busy_o
);
    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic [29:0]            off;
    logic                   in_range;
    logic                   cap_ok;
    logic                   par_err;
    logic                   rsp_err;
    logic                   unused_addr;
    logic [ReadLatency-1:0] valid_q;
    logic [ReadLatency-1:0] err_q;
    logic [CntW-1:0]        outstanding_q;
    logic [CntW-1:0]        outstanding_d;

    // Addresses below the base wrap to a huge offset and fall out of range.
    assign off         = instr_addr_i[31:2] - BaseAddr[31:2];
    assign in_range    = (off >> AddrWidth) == 30'd0;
    assign unused_addr = ^instr_addr_i[1:0];

    // A retire in the same cycle deliberately does not free a slot.
    assign cap_ok      = outstanding_q < MaxCnt;
    assign sram_req_o  = instr_req_i & in_range & cap_ok;
    assign sram_addr_o = sram_req_o ? off[AddrWidth-1:0] : '0;
    assign instr_gnt_o = instr_req_i & cap_ok & (in_range ? sram_gnt_i : 1'b1);

`ifdef IBEX_IBUS_PARITY_EN
    assign par_err = sram_parity_i != {^sram_rdata_i[31:24], ^sram_rdata_i[23:16],
                                       ^sram_rdata_i[15:8],  ^sram_rdata_i[7:0]};
`else
    assign par_err = 1'b0;
`endif

    assign instr_rvalid_o = valid_q[ReadLatency-1];
    assign rsp_err        = err_q[ReadLatency-1] | par_err;
    assign instr_err_o    = instr_rvalid_o & rsp_err;
    assign instr_rdata_o  = (instr_rvalid_o & ~rsp_err) ? sram_rdata_i : 32'h0;

    assign outstanding_d = outstanding_q + CntW'(instr_gnt_o) - CntW'(instr_rvalid_o);
    assign busy_o        = instr_req_i | (outstanding_q != '0);

    // Error tags ride the same pipeline as SRAM reads so responses stay in order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= '0;
            err_q         <= '0;
            outstanding_q <= '0;
        end else begin
            valid_q[0] <= instr_gnt_o;
            err_q[0]   <= instr_gnt_o & ~in_range;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
            outstanding_q <= outstanding_d;
        end
    end
endmodule

// File: tb/tb_ibex_instr_sram_bridge.sv
// tb/tb_ibex_instr_sram_bridge.sv - randomized and directed bench for ibex_instr_sram_bridge
module tb_ibex_instr_sram_bridge;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int          AW   = 12;
    localparam logic [31:0] KEY  = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic          instr_req_i  = 1'b0;
    logic [31:0]   instr_addr_i = '0;
    logic          sram_gnt_i   = 1'b0;
    logic [31:0]   sram_rdata_i = '0;
`ifdef IBEX_IBUS_PARITY_EN
    logic [3:0]    sram_parity_i = '0;
`endif

    logic          g0, rv0, e0, sr0, b0, g1, rv1, e1, sr1, b1;
    logic [31:0]   rd0, rd1;
    logic [AW-1:0] sa0, sa1;

    ibex_instr_sram_bridge u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(g0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0), .instr_err_o(e0),
        .sram_req_o(sr0), .sram_addr_o(sa0), .sram_gnt_i(sram_gnt_i), .sram_rdata_i(sram_rdata_i),
`ifdef IBEX_IBUS_PARITY_EN
        .sram_parity_i(sram_parity_i),
`endif
        .busy_o(b0));

    ibex_instr_sram_bridge #(.ReadLatency(3), .MaxOutstanding(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(g1), .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .instr_err_o(e1),
        .sram_req_o(sr1), .sram_addr_o(sa1), .sram_gnt_i(sram_gnt_i), .sram_rdata_i(sram_rdata_i),
`ifdef IBEX_IBUS_PARITY_EN
        .sram_parity_i(sram_parity_i),
`endif
        .busy_o(b1));

    bit sel = 1'b0;
    logic          o_gnt, o_rv, o_err, o_sreq, o_busy;
    logic [31:0]   o_rdata;
    logic [AW-1:0] o_saddr;
    assign o_gnt   = sel ? g1  : g0;
    assign o_rv    = sel ? rv1 : rv0;
    assign o_err   = sel ? e1  : e0;
    assign o_sreq  = sel ? sr1 : sr0;
    assign o_busy  = sel ? b1  : b0;
    assign o_rdata = sel ? rd1 : rd0;
    assign o_saddr = sel ? sa1 : sa0;

    // Reference: queue of accepted requests, each with the cycle its response is due.
    typedef struct {
        int          due;
        bit          err;
        logic [31:0] addr;
    } rsp_t;
    rsp_t q[$];

    int          t = 0;
    int          rl = 1;
    int          mo = 2;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          last_gnt = 1'b0;
    bit          bad_par = 1'b0;
    bit          data_ovr = 1'b0;
    logic [31:0] data_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (t=%0d sel=%0d): observed %0h expected %0h", tag, t, sel, obs, exp);
        end
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input bit sg);
        logic [29:0] off;
        logic [31:0] d, rd_e;
        bit          inr, capok, gnt_e, sreq_e, rv_e, err_e;
        int          cnt;
        @(negedge clk);
        while (q.size() > 0 && q[0].due < t) void'(q.pop_front());
        cnt   = q.size();
        rv_e  = (cnt > 0) && (q[0].due == t);
        err_e = rv_e && q[0].err;
        d     = rv_e ? (data_ovr ? data_val : (q[0].addr ^ KEY)) : $urandom;
        sram_rdata_i = d;
`ifdef IBEX_IBUS_PARITY_EN
        sram_parity_i = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
        if (rv_e && !err_e && bad_par) begin
            sram_parity_i[0] = ~sram_parity_i[0];
            err_e = 1'b1;
        end
`endif
        rd_e = (rv_e && !err_e) ? d : 32'h0;
        instr_req_i  = req;
        instr_addr_i = addr;
        sram_gnt_i   = sg;
        #1;
        off    = 30'((addr >> 2) - (BASE >> 2));
        inr    = off < 30'(1 << AW);
        capok  = cnt < mo;
        gnt_e  = req && capok && (inr ? sg : 1'b1);
        sreq_e = req && inr && capok;
        check("gnt", {31'd0, o_gnt}, {31'd0, gnt_e});
        check("sram_req", {31'd0, o_sreq}, {31'd0, sreq_e});
        check("sram_addr", 32'(o_saddr), sreq_e ? 32'(off % 4096) : 32'h0);
        check("rvalid", {31'd0, o_rv}, {31'd0, rv_e});
        check("err", {31'd0, o_err}, {31'd0, err_e});
        check("rdata", o_rdata, rd_e);
        check("busy", {31'd0, o_busy}, {31'd0, req || cnt != 0});
        if (gnt_e) q.push_back('{t + rl, !inr, addr});
        last_gnt = gnt_e;
        t++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        sram_gnt_i   = 1'b0;
        sram_rdata_i = $urandom;
        q.delete();
        #1;
        check("rst_rvalid", {31'd0, o_rv}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_gnt", {31'd0, o_gnt}, 32'd0);
        check("rst_sram_req", {31'd0, o_sreq}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic hold(input logic [31:0] a);
        int k = 0;
        last_gnt = 1'b0;
        while (!last_gnt && k < 8) begin
            step(1'b1, a, 1'b1);
            k++;
        end
        if (!last_gnt) check("hold_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_random(input int n);
        bit          pend = 1'b0;
        logic [31:0] a = '0;
        for (int i = 0; i < n; i++) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1'b1;
                case ($urandom_range(3))
                    0:       a = (BASE + ($urandom_range(4095) << 2)) | $urandom_range(3);
                    1:       a = $urandom;
                    2:       a = BASE + 32'h3FFC + ($urandom_range(1) << 2);
                    default: a = BASE - 4 * $urandom_range(1, 4);
                endcase
            end
            step(pend, pend ? a : $urandom, $urandom_range(3) != 0);
            if (last_gnt) pend = 1'b0;
        end
        repeat (5) step(1'b0, $urandom, 1'b1);
    endtask

    initial begin
        logic [31:0] a;

        sel = 1'b0; rl = 1; mo = 2;
        do_reset();

        step(1'b1, BASE, 1'b1);
        step(1'b1, BASE + 32'h4, 1'b1);
        step(1'b1, BASE + 32'h8, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        hold(32'h0010_3FFC);
        hold(32'h0010_4000);
        hold(32'h000F_FFFC);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        repeat (3) step(1'b1, BASE + 32'h10, 1'b0);
        step(1'b1, BASE + 32'h10, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        run_random(300);

        sel = 1'b1; rl = 3; mo = 2;
        do_reset();
        a = BASE;
        repeat (12) begin
            step(1'b1, a, 1'b1);
            if (last_gnt) a = a + 32'h4;
        end
        repeat (5) step(1'b0, 32'h0, 1'b1);

        run_random(300);

        step(1'b1, BASE + 32'h20, 1'b1);
        do_reset();
        repeat (5) step(1'b0, 32'h0, 1'b1);
        step(1'b1, BASE + 32'h24, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1);

`ifdef IBEX_IBUS_PARITY_EN
        sel = 1'b0; rl = 1; mo = 2;
        do_reset();
        data_ovr = 1'b1;
        data_val = 32'h0000_00FF;
        step(1'b1, BASE, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        bad_par = 1'b1;
        step(1'b1, BASE + 32'h4, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        bad_par  = 1'b0;
        data_ovr = 1'b0;
        run_random(100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_instr_sram_bridge.md
# ibex_instr_sram_bridge

Instruction-side bus slave between the prefetch buffer's `instr_req/gnt/rvalid` port and a shared single-port instruction SRAM behind an external arbiter. It accepts word-aligned fetch requests and range-checks them against a fixed base window. In-range requests are forwarded to the SRAM, and every request gets exactly one in-order response after a fixed latency. The bridge caps outstanding requests so a downstream consumer with bounded reservation space, such as a 2-entry fetch queue, is never overrun.

## Interface
- `AddrWidth`, 12: SRAM word-address width; window size is 4·2^AddrWidth bytes.
- `BaseAddr`, 32'h0010_0000: byte base of the window; bits [1:0] must be 0.
- `ReadLatency`, 1: cycles from accepted request to response; legal 1..3.
- `MaxOutstanding`, 2: maximum accepted-but-unanswered requests; legal 1..4.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1: fetch request, held until granted.
- `instr_addr_i` in 32: byte address; bits [1:0] ignored.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: response valid, one cycle.
- `instr_rdata_o` out 32: response data; 0 when `instr_err_o`.
- `instr_err_o` out 1: response error, qualified by `instr_rvalid_o`.
- `sram_req_o` out 1: SRAM read request.
- `sram_addr_o` out AddrWidth: SRAM word address.
- `sram_gnt_i` in 1: arbiter grant, same cycle as `sram_req_o`.
- `sram_rdata_i` in 32: SRAM read data, valid exactly ReadLatency cycles after a granted `sram_req_o`.
- `busy_o` out 1: `instr_req_i` high or `outstanding_q != 0`.

## Operation
- Offset computation: `off = instr_addr_i[31:2] - BaseAddr[31:2]`, 30-bit unsigned and wrapping.
- Range check: `in_range = (off >> AddrWidth) == 0`. Addresses below the base wrap to a large offset and are out of range.
- Capacity: `cap_ok = outstanding_q < MaxOutstanding`. This uses only the registered count; a same-cycle retire does not free a slot.
- SRAM request: `sram_req_o = instr_req_i & in_range & cap_ok`, with `sram_addr_o = off[AddrWidth-1:0]`. Both are 0 when idle.
- Grant: `instr_gnt_o = instr_req_i & cap_ok & (in_range ? sram_gnt_i : 1)`. Out-of-range requests never touch the SRAM.
- Tag pipeline: ReadLatency stages of `{valid, err}`. Stage 0 loads `{instr_gnt_o, ~in_range}` and all stages shift every cycle.
  - `instr_rvalid_o` is the last stage's valid bit.
  - `instr_rdata_o = err ? 0 : sram_rdata_i`.
  - Error responses take the same latency, so order is preserved.
- Outstanding count: `outstanding_q += instr_gnt_o - instr_rvalid_o`. Width is clog2(MaxOutstanding+1). It never exceeds MaxOutstanding and never underflows.
- No cancellation: branches upstream do not affect the bridge; discard is the consumer's job.

## Timing
- Reset values: tags 0, `outstanding_q` 0, so `instr_rvalid_o` 0 and `instr_err_o` 0. `instr_rdata_o` is 0 while not valid.
  - `instr_gnt_o` and `sram_req_o` are combinational from inputs and are 0 while `instr_req_i` is 0.
- Latency: a grant in cycle T produces `instr_rvalid_o` in cycle T+ReadLatency.
- Throughput: one response per cycle when MaxOutstanding > ReadLatency. Otherwise the bridge stalls.
  - Example: ReadLatency=1, MaxOutstanding=1 gives one grant every 2 cycles.
- Arbiter stall: when `sram_gnt_i` is 0, the request is held, no tag is loaded, and `sram_req_o` stays asserted.
- Simultaneous grant and retire: the count is unchanged.
- Address ungranted change: if `instr_addr_i` changes while ungranted (protocol violation), the bridge follows the new value with no latching.
- Reset mid-operation: all tags are cleared and in-flight responses are dropped. SRAM data arriving after reset is ignored.
- No combinational path from `sram_rdata_i` to `instr_gnt_o`.

## Configuration
- `IBEX_IBUS_PARITY_EN` defined:
  - Adds input `sram_parity_i` [3:0], with even parity per byte, aligned with `sram_rdata_i`.
  - A mismatch on an in-range response gives `instr_err_o`=1 and `instr_rdata_o`=0.
- `IBEX_IBUS_PARITY_EN` undefined: the port is absent and in-range responses never error.

## Test plan
- Defaults, `sram_gnt_i`=1, requests to 0x0010_0000, 0x0010_0004, 0x0010_0008 back-to-back, SRAM returning addr^0xA5A5A5A5 -> grants in cycles 0,1,2; `sram_addr_o` 0,1,2; rvalid in cycles 1,2,3 with matching data, err=0.
- Boundary addresses 0x0010_3FFC, 0x0010_4000 and 0x000F_FFFC -> first is granted with `sram_addr_o`=0xFFF, err=0. Second and third are granted with no `sram_req_o` and respond one cycle later with err=1, rdata=0.
- `sram_gnt_i` low for 3 cycles with a request held -> `sram_req_o` high and `instr_gnt_o` low for 3 cycles; grant on the 4th cycle, rvalid on the 5th, count never above 1.
- ReadLatency=3, MaxOutstanding=2, continuous request -> grants at 0,1, then stall until the first rvalid at 3. Count peaks at 2 and `busy_o` stays 1 throughout.
- `rst_ni` asserted the cycle after a grant -> no rvalid after reset release, count 0, `busy_o` follows `instr_req_i`.
- With `IBEX_IBUS_PARITY_EN`, data 0x000000FF with parity 4'b0000 -> rvalid with err=0. Parity 4'b0001 -> err=1, rdata=0.
